// File: rtl/rsa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// rsa_seq_ctrl
//
// Sequencer for one complete RSA modular exponentiation. It runs three
// phases back to back:
//   1. Montgomery precompute: R mod n and R^2 mod n on the shared rtMod unit,
//      then n'0 on modInv.
//   2. Word-serial load of the ModExp core (message, exponent, modulus,
//      R mod n and R^2 mod n words), followed by the compute/result controls.
//   3. Result readout as a stream of words, one per cycle, no backpressure.
// The host only supplies operand words (combinational read at op_addr) and
// a go pulse.
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   go                  start pulse, sampled only while idle
//   busy, done          operation in flight / one-cycle completion pulse
//   op_addr             word index into the host operand file
//   m_word/e_word/n_word  host operand words at op_addr, same cycle
//   n_full              full modulus; routed to rtMod/modInv outside
//   rt_go, rt_mode      rtMod start pulse and mode (0: R mod n, 1: R^2 mod n)
//   rt_out, rt_done     rtMod result and completion
//   inv_go              modInv start pulse
//   inv_out, inv_valid  modInv result and valid
//   m_buf..t_buf        registered word bus to ModExp
//   nprime0             n'0 to ModExp
//   startInput, startCompute, getResult  ModExp controls
//   exp_state, res_out  ModExp state (9 = complete) and result word
//   res_word, res_idx, res_valid  result stream to the host
// ---------------------------------------------------------------------------
module rsa_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            go,
  output logic                            busy,
  output logic                            done,
  output logic [5:0]                      op_addr,
  input  logic [DATA_WIDTH-1:0]           m_word,
  input  logic [DATA_WIDTH-1:0]           e_word,
  input  logic [DATA_WIDTH-1:0]           n_word,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] n_full,
  output logic                            rt_go,
  output logic                            rt_mode,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0] rt_out,
  input  logic                            rt_done,
  output logic                            inv_go,
  input  logic [63:0]                     inv_out,
  input  logic                            inv_valid,
  output logic [DATA_WIDTH-1:0]           m_buf,
  output logic [DATA_WIDTH-1:0]           e_buf,
  output logic [DATA_WIDTH-1:0]           n_buf,
  output logic [DATA_WIDTH-1:0]           r_buf,
  output logic [DATA_WIDTH-1:0]           t_buf,
  output logic [63:0]                     nprime0,
  output logic                            startInput,
  output logic                            startCompute,
  output logic                            getResult,
  input  logic [4:0]                      exp_state,
  input  logic [DATA_WIDTH-1:0]           res_out,
  output logic [DATA_WIDTH-1:0]           res_word,
  output logic [5:0]                      res_idx,
  output logic                            res_valid
);

  localparam int unsigned FullW = DATA_WIDTH * NUM_WORDS;
  localparam int unsigned IdxW  = 6;

  localparam logic [CNT_W-1:0] LastCnt     = CNT_W'(NUM_WORDS);
  localparam logic [4:0]       ExpComplete = 5'd9;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CALC_R   = 3'd1;
  localparam logic [2:0] CALC_T   = 3'd2;
  localparam logic [2:0] CALC_N0  = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;
  localparam logic [2:0] WAIT_EXP = 3'd5;
  localparam logic [2:0] READ     = 3'd6;
  localparam logic [2:0] DONE     = 3'd7;

  // The full modulus only passes by this block on its way to rtMod/modInv.
  logic unused_n_full;
  assign unused_n_full = ^n_full;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FullW-1:0]      r_q, r_d;
  logic [FullW-1:0]      t_q, t_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rt_go_q, rt_go_d;
  logic                  rt_mode_q, rt_mode_d;
  logic                  inv_go_q, inv_go_d;
  logic [DATA_WIDTH-1:0] m_buf_q, m_buf_d;
  logic [DATA_WIDTH-1:0] e_buf_q, e_buf_d;
  logic [DATA_WIDTH-1:0] n_buf_q, n_buf_d;
  logic [DATA_WIDTH-1:0] r_buf_q, r_buf_d;
  logic [DATA_WIDTH-1:0] t_buf_q, t_buf_d;
  logic [63:0]           nprime0_q, nprime0_d;
  logic                  start_input_q, start_input_d;
  logic                  start_compute_q, start_compute_d;
  logic                  get_result_q, get_result_d;
  logic [DATA_WIDTH-1:0] res_word_q, res_word_d;
  logic [IdxW-1:0]       res_idx_q, res_idx_d;
  logic                  res_valid_q, res_valid_d;

  // Word views of the captured precompute results, indexed by the counter.
  logic [DATA_WIDTH-1:0] r_words [NUM_WORDS];
  logic [DATA_WIDTH-1:0] t_words [NUM_WORDS];

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_words
    assign r_words[w] = r_q[w*DATA_WIDTH +: DATA_WIDTH];
    assign t_words[w] = t_q[w*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [IdxW-1:0] word_idx;
  assign word_idx = cnt_q[IdxW-1:0];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    r_d             = r_q;
    t_d             = t_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rt_go_d         = 1'b0;
    rt_mode_d       = rt_mode_q;
    inv_go_d        = 1'b0;
    m_buf_d         = m_buf_q;
    e_buf_d         = e_buf_q;
    n_buf_d         = n_buf_q;
    r_buf_d         = r_buf_q;
    t_buf_d         = t_buf_q;
    nprime0_d       = nprime0_q;
    start_input_d   = start_input_q;
    start_compute_d = start_compute_q;
    get_result_d    = get_result_q;
    res_word_d      = res_word_q;
    res_idx_d       = res_idx_q;
    res_valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          rt_go_d   = 1'b1;
          rt_mode_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = CALC_R;
        end
      end

      // rt_done is not trusted while our own start pulse is still on the wire.
      CALC_R: begin
        if (rt_done && !rt_go_q) begin
          r_d       = rt_out;
          rt_mode_d = 1'b1;
          rt_go_d   = 1'b1;
          state_d   = CALC_T;
        end
      end

      CALC_T: begin
        if (rt_done && !rt_go_q) begin
          t_d      = rt_out;
          inv_go_d = 1'b1;
          state_d  = CALC_N0;
        end
      end

      CALC_N0: begin
        if (inv_valid) begin
          nprime0_d     = inv_out;
          cnt_d         = '0;
          start_input_d = 1'b1;
          state_d       = SEND;
        end
      end

      // Counter values 0..NUM_WORDS-1 load one word each; the final count is
      // the cycle that hands over to compute.
      SEND: begin
        if (cnt_q == LastCnt) begin
          start_compute_d = 1'b1;
          get_result_d    = 1'b1;
          cnt_d           = '0;
          state_d         = WAIT_EXP;
        end else begin
          m_buf_d = m_word;
          e_buf_d = e_word;
          n_buf_d = n_word;
          r_buf_d = r_words[word_idx];
          t_buf_d = t_words[word_idx];
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      WAIT_EXP: begin
        if (exp_state == ExpComplete) begin
          cnt_d   = '0;
          state_d = READ;
        end
      end

      // Count 0 is a discard cycle while ModExp presents its first word.
      READ: begin
        if (cnt_q != '0) begin
          res_word_d  = res_out;
          res_idx_d   = word_idx - IdxW'(1);
          res_valid_d = 1'b1;
        end
        if (cnt_q == LastCnt) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        done_d          = 1'b1;
        busy_d          = 1'b0;
        start_input_d   = 1'b0;
        start_compute_d = 1'b0;
        get_result_d    = 1'b0;
        state_d         = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      r_q             <= '0;
      t_q             <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rt_go_q         <= 1'b0;
      rt_mode_q       <= 1'b0;
      inv_go_q        <= 1'b0;
      m_buf_q         <= '0;
      e_buf_q         <= '0;
      n_buf_q         <= '0;
      r_buf_q         <= '0;
      t_buf_q         <= '0;
      nprime0_q       <= '0;
      start_input_q   <= 1'b0;
      start_compute_q <= 1'b0;
      get_result_q    <= 1'b0;
      res_word_q      <= '0;
      res_idx_q       <= '0;
      res_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      r_q             <= r_d;
      t_q             <= t_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rt_go_q         <= rt_go_d;
      rt_mode_q       <= rt_mode_d;
      inv_go_q        <= inv_go_d;
      m_buf_q         <= m_buf_d;
      e_buf_q         <= e_buf_d;
      n_buf_q         <= n_buf_d;
      r_buf_q         <= r_buf_d;
      t_buf_q         <= t_buf_d;
      nprime0_q       <= nprime0_d;
      start_input_q   <= start_input_d;
      start_compute_q <= start_compute_d;
      get_result_q    <= get_result_d;
      res_word_q      <= res_word_d;
      res_idx_q       <= res_idx_d;
      res_valid_q     <= res_valid_d;
    end
  end

  // Address is only meaningful while loading; hold it at zero otherwise.
  assign op_addr      = (state_q == SEND) ? word_idx : '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign rt_go        = rt_go_q;
  assign rt_mode      = rt_mode_q;
  assign inv_go       = inv_go_q;
  assign m_buf        = m_buf_q;
  assign e_buf        = e_buf_q;
  assign n_buf        = n_buf_q;
  assign r_buf        = r_buf_q;
  assign t_buf        = t_buf_q;
  assign nprime0      = nprime0_q;
  assign startInput   = start_input_q;
  assign startCompute = start_compute_q;
  assign getResult    = get_result_q;
  assign res_word     = res_word_q;
  assign res_idx      = res_idx_q;
  assign res_valid    = res_valid_q;

endmodule
